// File: rtl/reg_file.sv
// Register file with two registered read ports (A, B) and one write port (D), gated by i_en.
// Optional macro REGFILE_BYPASS_EN: a write to the register being read is forwarded to the output.
module reg_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_selA,
  input  logic [ADDR_W-1:0] i_selB,
  input  logic [ADDR_W-1:0] i_selD,
  input  logic [DATA_W-1:0] i_dataD,
  output logic [DATA_W-1:0] o_dataA,
  output logic [DATA_W-1:0] o_dataB
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  logic              wr_en;

  assign wr_en = i_en & i_we;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[i_selD] = i_dataD;
    end
  end

  // Reads see the pre-write array (read-before-write) unless bypass is built in.
  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (i_en) begin
      data_a_d = regs_q[i_selA];
      data_b_d = regs_q[i_selB];
`ifdef REGFILE_BYPASS_EN
      if (i_we && (i_selA == i_selD)) begin
        data_a_d = i_dataD;
      end
      if (i_we && (i_selB == i_selD)) begin
        data_b_d = i_dataD;
      end
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      regs_q   <= regs_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign o_dataA = data_a_q;
  assign o_dataB = data_b_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, reset/sweep sequences, random vs model.
module tb_reg_file;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          we;
  logic [AW-1:0] sel_a;
  logic [AW-1:0] sel_b;
  logic [AW-1:0] sel_d;
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;

  int checks;
  int failures;

  // Reference model: plain array of register contents plus expected outputs.
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_a;
  logic [DW-1:0] m_b;

  reg_file #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_en   (en),
    .i_we   (we),
    .i_selA (sel_a),
    .i_selB (sel_b),
    .i_selD (sel_d),
    .i_dataD(data_d),
    .o_dataA(data_a),
    .o_dataB(data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] d;
    logic [DW-1:0] dd;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_a = '0;
    m_b = '0;
  endtask

  // Drive one cycle's inputs, let one rising edge pass, update the model from the rules.
  task automatic tick(input logic e, input logic w, input logic [AW-1:0] a,
                      input logic [AW-1:0] b, input logic [AW-1:0] d, input logic [DW-1:0] dd);
    logic [DW-1:0] na, nb;
    en = e; we = w; sel_a = a; sel_b = b; sel_d = d; data_d = dd;
    na = m_a;
    nb = m_b;
    if (e) begin
      na = m_regs[a];
      nb = m_regs[b];
`ifdef REGFILE_BYPASS_EN
      if (w && a == d) na = dd;
      if (w && b == d) nb = dd;
`endif
    end
    @(posedge clk);
    #1;
    m_a = na;
    m_b = nb;
    if (e && w) m_regs[d] = dd;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("reset_async_a", data_a, '0);
    check("reset_async_b", data_b, '0);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [DW-1:0] ea, eb;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    en = 1'b0; we = 1'b0; sel_a = '0; sel_b = '0; sel_d = '0; data_d = '0;
    model_clear();
    @(posedge clk);
    #1;
    check("reset_state_a", data_a, '0);
    check("reset_state_b", data_b, '0);
    rst_n = 1'b1;

    // Directed table, read-before-write expectations; bypass adjustments applied below.
    vecs[0]  = '{1, 1, 0, 1, 0, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[1]  = '{1, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[2]  = '{1, 0, 2, 0, 2, 16'h2222, 16'h0000, 16'hFFFF};
    vecs[3]  = '{1, 1, 2, 2, 2, 16'h2222, 16'h0000, 16'h0000};
    vecs[4]  = '{1, 1, 2, 0, 2, 16'h3333, 16'h2222, 16'hFFFF};
    vecs[5]  = '{1, 0, 2, 2, 0, 16'h0000, 16'h3333, 16'h3333};
    vecs[6]  = '{0, 1, 4, 4, 4, 16'h4444, 16'h3333, 16'h3333};
    vecs[7]  = '{0, 1, 4, 4, 4, 16'h4444, 16'h3333, 16'h3333};
    vecs[8]  = '{0, 1, 4, 4, 4, 16'h4444, 16'h3333, 16'h3333};
    vecs[9]  = '{1, 1, 4, 0, 4, 16'h4444, 16'h0000, 16'hFFFF};
    vecs[10] = '{1, 0, 4, 4, 0, 16'h0000, 16'h4444, 16'h4444};
    vecs[11] = '{1, 1, 0, 0, 3, 16'h0101, 16'hFFFF, 16'hFFFF};
    vecs[12] = '{1, 1, 3, 1, 3, 16'hA5A5, 16'h0101, 16'h0000};
    vecs[13] = '{1, 0, 3, 3, 0, 16'h0000, 16'hA5A5, 16'hA5A5};

    for (int i = 0; i < 14; i++) begin
      ea = vecs[i].exp_a;
      eb = vecs[i].exp_b;
`ifdef REGFILE_BYPASS_EN
      if (vecs[i].en && vecs[i].we && vecs[i].a == vecs[i].d) ea = vecs[i].dd;
      if (vecs[i].en && vecs[i].we && vecs[i].b == vecs[i].d) eb = vecs[i].dd;
`endif
      tick(vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].dd);
      check($sformatf("vec%0d_a", i), data_a, ea);
      check($sformatf("vec%0d_b", i), data_b, eb);
    end

    // Reset mid-operation: reg 5 written and visible, then cleared asynchronously.
    reset_pulse();
    tick(1, 1, 0, 0, 5, 16'h1234);
    tick(1, 0, 5, 5, 0, 16'h0000);
    check("pre_reset_r5", data_a, 16'h1234);
    reset_pulse();
    tick(1, 0, 5, 5, 0, 16'h0000);
    check("post_reset_r5_a", data_a, 16'h0000);
    check("post_reset_r5_b", data_b, 16'h0000);

    // Sweep: write i*0x1111, then read every (A,B) pair.
    for (int i = 0; i < NR; i++) tick(1, 1, 0, 0, AW'(i), DW'(16'h1111 * i));
    for (int a = 0; a < NR; a++) begin
      for (int b = 0; b < NR; b++) begin
        tick(1, 0, AW'(a), AW'(b), 0, 16'h0000);
        check($sformatf("sweep_a%0d", a), data_a, DW'(16'h1111 * a));
        check($sformatf("sweep_b%0d", b), data_b, DW'(16'h1111 * b));
      end
    end

    // Random traffic against the model.
    reset_pulse();
    for (int n = 0; n < 400; n++) begin
      tick(($urandom_range(0, 3) != 0), $urandom_range(0, 1), AW'($urandom_range(0, NR - 1)),
           AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)), DW'($urandom));
      check("rand_a", data_a, m_a);
      check("rand_b", data_b, m_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file for the 16-bit RISC processor datapath.
- Holds NUM_REGS registers of DATA_W bits.
- Provides two registered read ports (A, B) feeding the ALU operands and one synchronous write port (D) written back from the execute/writeback stage.
- All activity is gated by a stage enable from the control unit.

Parameters:
- DATA_W, 16, width of each register and of all data ports.
- ADDR_W, 3, width of each select input; NUM_REGS = 2**ADDR_W (8 by default), derived, not overridable.

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  stage enable; when low, the block holds all state.
- i_we  input  1  write enable for port D, qualified by i_en.
- i_selA  input  ADDR_W  register index for read port A.
- i_selB  input  ADDR_W  register index for read port B.
- i_selD  input  ADDR_W  register index for write port D.
- i_dataD  input  DATA_W  write data for port D.
- o_dataA  output  DATA_W  registered read data, port A.
- o_dataB  output  DATA_W  registered read data, port B.

Behaviour:
- Reset (i_rst_n low, asynchronous, independent of i_clk):
  - all NUM_REGS registers clear to 0;
  - o_dataA = o_dataB = 0.
  - Deassertion takes effect at the next rising edge; no clock is needed to enter reset.
  - Reset mid-operation discards any write pending in that cycle.
- Rising edge with i_en = 1:
  - o_dataA <= reg[i_selA];
  - o_dataB <= reg[i_selB];
  - if i_we = 1: reg[i_selD] <= i_dataD.
- Read latency: 1 cycle. Outputs change only on a rising edge with i_en = 1, or on reset.
- Rising edge with i_en = 0: no register written, even if i_we = 1; outputs hold their previous value.
- No hardwired-zero register: register 0 is writable like any other.
- Read/write collision (i_selA or i_selB equal to i_selD, i_we = 1, same edge), without the optional feature:
  - read-before-write: the output captures the old register content;
  - the new value appears on the next enabled edge.
- selA = selB: both outputs capture the same value.
- All indices 0..NUM_REGS-1 are valid; there is no out-of-range case.
- Write data is stored unmodified: no sign extension, no truncation.
- i_we and the selects are sampled only at the rising edge; glitches between edges have no effect.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass on a collision (i_en = 1, i_we = 1, i_selA == i_selD). o_dataA <= i_dataD in that same edge; port B is handled identically. Register update is unchanged.
- Undefined: read-before-write as described in Behaviour.
- No other behaviour differs between builds.

Test Plan:
- Reset: write 16'h1234 to reg 5, then pulse i_rst_n low between clock edges -> o_dataA and o_dataB become 0 immediately; reading reg 5 afterwards returns 0.
- Write/read: i_en=1, i_we=1, selD=0, dataD=16'hFFFF, selA=0, selB=1. First edge -> o_dataA=0 (read-before-write). Next edge with we=0 -> o_dataA=16'hFFFF, o_dataB=0.
- Write-enable gating: selD=2, dataD=16'h2222, we=0 for one edge -> reg 2 unchanged. Then we=1 -> reg 2=16'h2222. Then dataD=16'h3333 -> reg 2=16'h3333 (last write wins).
- Enable gating: i_en=0, we=1, selD=4, dataD=16'h4444 for 3 edges -> reg 4 stays 0 and outputs frozen. Then i_en=1 -> reg 4=16'h4444; selA=selB=4 -> both outputs 16'h4444 one edge later.
- Collision: selA=selD=3, we=1, dataD=16'hA5A5, reg 3 previously 16'h0101 -> o_dataA=16'h0101 without the macro, 16'hA5A5 with REGFILE_BYPASS_EN.
- Sweep: write index i with value {i,i,i,i} for all 8 registers, then read every pair (A, B) -> each output matches the stored value with 1-cycle latency.
